// File: rtl/approx_mul_pkg.sv
// Shared types and constants for the iterative approximate multiplier.
// Optional feature macro: APPROX_MUL_EXACT_EN (adds a per-operation exact-mode input).
package approx_mul_pkg;

  // Controller states: waiting for operands, accumulating digit products, holding the result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Approximate 3x3 digit product (exact value would be 9)
  localparam logic [3:0] APPROX_3X3 = 4'd7;

endpackage

// File: rtl/approx_mul_2x2_cell.sv
// Combinational 2-bit x 2-bit digit multiplier with an approximate 3x3 case.
// With APPROX_MUL_EXACT_EN defined, an exact input restores 3x3 = 9.
module approx_mul_2x2_cell
  import approx_mul_pkg::*;
(
  input  logic [1:0] x,
  input  logic [1:0] y,
`ifdef APPROX_MUL_EXACT_EN
  input  logic       exact,
`endif
  output logic [3:0] p
);

  // Exact product for every digit pair except 3x3, which is replaced by APPROX_3X3
  always_comb begin
    p = {2'b00, x} * {2'b00, y};
    if (x == 2'd3 && y == 2'd3) begin
`ifdef APPROX_MUL_EXACT_EN
      p = exact ? 4'd9 : APPROX_3X3;
`else
      p = APPROX_3X3;
`endif
    end
  end

endmodule

// File: rtl/approx_mul_iter.sv
// Iterative approximate unsigned multiplier: one 2x2 digit product per cycle,
// j-outer / i-inner, D*D cycles per operation, valid/ready on both sides.
// Optional feature macro: APPROX_MUL_EXACT_EN (adds input exact, latched at acceptance).
// WIDTH must be even and at least 2.
module approx_mul_iter
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef APPROX_MUL_EXACT_EN
  input  logic                 exact,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out
);

  localparam int D  = WIDTH / 2;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  state_t                state_reg, state_next;
  logic [WIDTH-1:0]      a_reg, b_reg;
  logic [2*WIDTH-1:0]    acc_reg;
  logic [CW-1:0]         i_reg, j_reg;
`ifdef APPROX_MUL_EXACT_EN
  logic                  exact_reg;
`endif

  logic [1:0]            a_dig [D];
  logic [1:0]            b_dig [D];
  logic [3:0]            dp;
  logic [2*WIDTH-1:0]    dp_ext;
  logic [2*WIDTH-1:0]    term;
  logic [CW+1:0]         sh;
  logic                  accept;
  logic                  step;
  logic                  last_step;

  // Split latched operands into two-bit digits, digit 0 at the LSBs
  for (genvar gi = 0; gi < D; gi++) begin : g_digits
    assign a_dig[gi] = a_reg[2*gi +: 2];
    assign b_dig[gi] = b_reg[2*gi +: 2];
  end

  approx_mul_2x2_cell u_cell (
    .x     (a_dig[i_reg]),
    .y     (b_dig[j_reg]),
`ifdef APPROX_MUL_EXACT_EN
    .exact (exact_reg),
`endif
    .p     (dp)
  );

  // Widen the digit product and place it at weight 4^(i+j)
  always_comb begin
    dp_ext      = '0;
    dp_ext[3:0] = dp;
    sh          = {1'b0, i_reg, 1'b0} + {1'b0, j_reg, 1'b0};
    term        = dp_ext << sh;
  end

  assign accept    = (state_reg == IDLE) && in_valid;
  assign step      = (state_reg == BUSY);
  assign last_step = (i_reg == LAST) && (j_reg == LAST);

  // State register; reset wins over any handshake in the same cycle
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last_step) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, digit counters and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      i_reg     <= '0;
      j_reg     <= '0;
`ifdef APPROX_MUL_EXACT_EN
      exact_reg <= 1'b0;
`endif
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      acc_reg   <= '0;
      i_reg     <= '0;
      j_reg     <= '0;
`ifdef APPROX_MUL_EXACT_EN
      exact_reg <= exact;
`endif
    end else if (step) begin
      acc_reg <= acc_reg + term;
      if (last_step) begin
        i_reg <= '0;
        j_reg <= '0;
      end else if (i_reg == LAST) begin
        i_reg <= '0;
        j_reg <= j_reg + 1'b1;
      end else begin
        i_reg <= i_reg + 1'b1;
      end
    end
  end

  // Result is only visible while it is being offered
  assign out = (state_reg == DONE) ? acc_reg : '0;

endmodule

// File: tb/tb_approx_mul_iter.sv
// Directed bench for approx_mul_iter at WIDTH=8 and WIDTH=4.
module tb_approx_mul_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] out8;
  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]  a4, b4;
  logic [7:0]  out4;
  logic        exact8, exact4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  approx_mul_iter #(.WIDTH(8)) u8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
`ifdef APPROX_MUL_EXACT_EN
    .exact     (exact8),
`endif
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out       (out8)
  );

  approx_mul_iter #(.WIDTH(4)) u4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
`ifdef APPROX_MUL_EXACT_EN
    .exact     (exact4),
`endif
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out       (out4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One W=8 operation: latency, value, optional DONE hold, return to IDLE
  task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                      input int exp_out, input int hold);
    int  n;
    bit  seen;
    @(negedge clk);
    out_ready8 = (hold == 0);
    a8 = ta; b8 = tb; in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid8) seen = 1;
      else if (n == 3) begin
        chk({tag, " in_ready_busy"}, in_ready8, 0);
        in_valid8 = 1'b1; a8 = 8'hA5; b8 = 8'h5A;
      end else if (n == 4) begin
        in_valid8 = 1'b0;
      end else if (n == 5) begin
        chk({tag, " out_zero_busy"}, out8, 0);
      end
    end
    $display("txn W8 %s a=%0d b=%0d out=%0d latency=%0d", tag, ta, tb, out8, n);
    chk({tag, " latency"}, n, 16);
    chk({tag, " out"}, out8, exp_out);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, " hold_valid"}, out_valid8, 1);
      chk({tag, " hold_out"}, out8, exp_out);
    end
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " idle_ready"}, in_ready8, 1);
    chk({tag, " idle_valid"}, out_valid8, 0);
    chk({tag, " idle_out"}, out8, 0);
  endtask

  // One W=4 operation: latency of 4 BUSY cycles and value
  task automatic run4(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                      input logic ex, input int exp_out);
    int n;
    bit seen;
    @(negedge clk);
    out_ready4 = 1'b1;
    a4 = ta; b4 = tb; exact4 = ex; in_valid4 = 1'b1;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid4) seen = 1;
    end
    $display("txn W4 %s a=%0d b=%0d out=%0d latency=%0d", tag, ta, tb, out4, n);
    chk({tag, " latency"}, n, 4);
    chk({tag, " out"}, out4, exp_out);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " idle_valid"}, out_valid4, 0);
    chk({tag, " idle_ready"}, in_ready4, 1);
  endtask

  initial begin
    bit stray;
    rst = 1'b1;
    in_valid8 = 0; out_ready8 = 1; a8 = 0; b8 = 0; exact8 = 0;
    in_valid4 = 0; out_ready4 = 1; a4 = 0; b4 = 0; exact4 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready8", in_ready8, 1);
    chk("reset out_valid8", out_valid8, 0);
    chk("reset out8", out8, 0);
    chk("reset in_ready4", in_ready4, 1);
    chk("reset out_valid4", out_valid4, 0);
    rst = 1'b0;

    run8("ff_x_ff", 8'd255, 8'd255, 50575, 0);
    run8("zero_x_200", 8'd0, 8'd200, 0, 0);
    run8("hold5", 8'd255, 8'd255, 50575, 5);
    run8("b2b_3x3", 8'd3, 8'd3, 7, 0);

    run4("f_x_f", 4'd15, 4'd15, 1'b0, 175);
    run4("6_x_5", 4'd6, 4'd5, 1'b0, 30);
`ifdef APPROX_MUL_EXACT_EN
    run4("f_x_f_exact", 4'd15, 4'd15, 1'b1, 225);
`endif

    // Abort at BUSY cycle 7 via reset, then a fresh operation
    @(negedge clk);
    out_ready8 = 1'b1; a8 = 8'd255; b8 = 8'd255; in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("txn W8 abort in_ready=%0d out_valid=%0d out=%0d", in_ready8, out_valid8, out8);
    chk("abort in_ready", in_ready8, 1);
    chk("abort out_valid", out_valid8, 0);
    chk("abort out", out8, 0);
    stray = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid8) stray = 1;
    end
    chk("abort no_result", stray, 0);
    run8("post_abort_3x3", 8'd3, 8'd3, 7, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
